// File: rtl/il_pkg.sv
// il_pkg: opcodes, source selects, FSM state and write-class types shared by il_sequencer
package il_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {W_NONE, W_ACC, W_MEM, W_JMP, W_JMPC} wclass_t;
  localparam logic [1:0] SRC_BIT = 2'd0, SRC_WORD = 2'd1, SRC_RF = 2'd2, SRC_IMM = 2'd3;
  localparam logic [7:0] OP_NOT = 8'h06, OP_ADD = 8'h07, OP_SUB = 8'h08, OP_DIV = 8'h0A, OP_MOD = 8'h0B;
  localparam logic [7:0] OP_LAST2 = 8'h11, OP_S = 8'h1B, OP_R = 8'h1C, OP_ST = 8'h1D, OP_STN = 8'h1E;
  localparam logic [7:0] OP_LD = 8'h1F, OP_JMP = 8'h20, OP_JMPC = 8'h21, OP_HALT = 8'hFF;
endpackage

// File: rtl/il_decode.sv
// il_decode: opcode -> source selects, write class, legality; IL_JUMP_EN makes JMP/JMPC legal
module il_decode import il_pkg::*; #(
  parameter int IWIDTH = 8
) (
  input  logic [IWIDTH-1:0] op,
  input  logic [1:0]        src,
  output logic [1:0]        s1,
  output logic [1:0]        s2,
  output wclass_t           wclass,
  output logic              illegal,
  output logic              halt
);
  logic two_op, store, ld, jmp, jmpc;
  // classify the opcode and derive operand routing
  always_comb begin
    two_op = op <= IWIDTH'(OP_LAST2);
    store = op == IWIDTH'(OP_S) || op == IWIDTH'(OP_R) || op == IWIDTH'(OP_ST) || op == IWIDTH'(OP_STN);
    ld = op == IWIDTH'(OP_LD);
`ifdef IL_JUMP_EN
    jmp = op == IWIDTH'(OP_JMP);
    jmpc = op == IWIDTH'(OP_JMPC);
`else
    jmp = 1'b0;
    jmpc = 1'b0;
`endif
    halt = op == IWIDTH'(OP_HALT);
    illegal = !(two_op || store || ld || jmp || jmpc || halt);
    s1 = ld ? src : (two_op || store) ? SRC_RF : SRC_BIT;
    s2 = (two_op && op != IWIDTH'(OP_NOT)) ? src : SRC_BIT;
    wclass = (two_op || ld) ? W_ACC : store ? W_MEM : jmp ? W_JMP : jmpc ? W_JMPC : W_NONE;
  end
endmodule

// File: rtl/il_sequencer.sv
// il_sequencer: fetch/decode/exec/writeback accumulator sequencer; define IL_JUMP_EN for JMP/JMPC
module il_sequencer import il_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic [PC_WIDTH-1:0]      prog_addr,
  output logic                     prog_req,
  input  logic                     prog_ack,
  input  logic [IWIDTH+2+WIDTH-1:0] prog_data,
  output logic [IWIDTH-1:0]        op_code,
  output logic [1:0]               source1_choice,
  output logic [1:0]               source2_choice,
  output logic [WIDTH-1:0]         imm,
  output logic                     alu_c_in,
  output logic                     alu_b_in,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_c_out,
  input  logic                     alu_b_out,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         acc,
  output logic                     halted,
  output logic                     err
);
  localparam int DW = IWIDTH + 2 + WIDTH;
  state_t state_q, state_d;
  wclass_t wc_q, wc_d, dec_wc;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [IWIDTH-1:0] op_q, op_d;
  logic [1:0] s1_q, s1_d, s2_q, s2_d, dec_s1, dec_s2;
  logic [WIDTH-1:0] imm_q, imm_d, acc_q, acc_d;
  logic c_q, c_d, b_q, b_d, dec_ill, dec_halt, dec, wb, div_zero, take;
  il_decode #(.IWIDTH(IWIDTH)) u_dec (
    .op(instr_q[DW-1 -: IWIDTH]), .src(instr_q[WIDTH +: 2]), .s1(dec_s1), .s2(dec_s2),
    .wclass(dec_wc), .illegal(dec_ill), .halt(dec_halt)
  );
  assign dec = state_q == S_DECODE;
  assign wb = state_q == S_WB;
  assign div_zero = (op_q == IWIDTH'(OP_DIV) || op_q == IWIDTH'(OP_MOD)) && s2_q == SRC_IMM && imm_q == '0;
  assign take = wc_q == W_JMP || (wc_q == W_JMPC && acc_q[0]);
  // state register
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // next state: illegal opcodes skip EXEC/WB, halt is sticky until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = prog_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_halt ? S_HALT : dec_ill ? (run ? S_FETCH : S_IDLE) : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = state_q;
    endcase
  end
  // state-decoded strobes
  always_comb begin
    prog_req = state_q == S_FETCH;
    halted = state_q == S_HALT;
    mem_we = wb && wc_q == W_MEM;
    err = (dec && dec_ill) || (wb && div_zero);
  end
  // datapath next values: latch on ack, register decode, commit in writeback
  always_comb begin
    instr_d = (state_q == S_FETCH && prog_ack) ? prog_data : instr_q;
    op_d = dec ? instr_q[DW-1 -: IWIDTH] : op_q;
    s1_d = dec ? dec_s1 : s1_q;
    s2_d = dec ? dec_s2 : s2_q;
    imm_d = dec ? instr_q[WIDTH-1:0] : imm_q;
    wc_d = dec ? dec_wc : wc_q;
    acc_d = (wb && wc_q == W_ACC && !div_zero) ? alu_out : acc_q;
    c_d = (wb && op_q == IWIDTH'(OP_ADD)) ? alu_c_out : c_q;
    b_d = (wb && op_q == IWIDTH'(OP_SUB)) ? alu_b_out : b_q;
    pc_d = wb ? (take ? PC_WIDTH'(imm_q) : pc_q + PC_WIDTH'(1)) : (dec && dec_ill) ? pc_q + PC_WIDTH'(1) : pc_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      op_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      imm_q <= '0;
      wc_q <= W_NONE;
      acc_q <= '0;
      c_q <= 1'b0;
      b_q <= 1'b0;
      pc_q <= '0;
    end else begin
      instr_q <= instr_d;
      op_q <= op_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      imm_q <= imm_d;
      wc_q <= wc_d;
      acc_q <= acc_d;
      c_q <= c_d;
      b_q <= b_d;
      pc_q <= pc_d;
    end
  end
  assign prog_addr = pc_q;
  assign op_code = op_q;
  assign source1_choice = s1_q;
  assign source2_choice = s2_q;
  assign imm = imm_q;
  assign acc = acc_q;
  assign alu_c_in = c_q;
  assign alu_b_in = b_q;
endmodule

// File: doc/il_sequencer.md
IL_SEQUENCER -- requirements
Module: il_sequencer

Interface
REQ-001 WIDTH, 8, data/operand width; SHALL size all ALU-facing data ports.
REQ-002 IWIDTH, 8, opcode width; SHALL size op_code.
REQ-003 PC_WIDTH, 8, program counter width; SHALL size prog_addr.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 run  in  1  level; high SHALL permit instruction fetch.
REQ-007 prog_addr  out  PC_WIDTH  program memory address (PC).
REQ-008 prog_req  out  1  fetch request.
REQ-009 prog_ack  in  1  fetch acknowledge; prog_data valid in the same cycle.
REQ-010 prog_data  in  IWIDTH+2+WIDTH  instruction {opcode, src[1:0], operand}.
REQ-011 op_code  out  IWIDTH  opcode to ALU.
REQ-012 source1_choice  out  2  ALU A select: 0 bit_mem, 1 word_mem, 2 rf (accumulator), 3 imm.
REQ-013 source2_choice  out  2  ALU B select, same encoding.
REQ-014 imm  out  WIDTH  operand field, drives ALU imm_a/imm_b and memory address.
REQ-015 alu_c_in / alu_b_in  out  1 each  carry / borrow flag to ALU.
REQ-016 alu_out  in  WIDTH  ALU result.
REQ-017 alu_c_out / alu_b_out  in  1 each  ALU carry / borrow.
REQ-018 mem_we  out  1  one-cycle data-memory write strobe; address = imm, data = alu_out.
REQ-019 acc  out  WIDTH  accumulator (ALU rf operand).
REQ-020 halted  out  1  high while in HALT.
REQ-021 err  out  1  one-cycle pulse on illegal opcode or DIV/MOD by zero.

Function
REQ-022 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; IDLE->FETCH when run=1; FETCH->DECODE on prog_ack=1; DECODE->EXEC; EXEC->WB; WB->FETCH if run=1, else IDLE.
REQ-023 In FETCH, prog_req SHALL be high and prog_addr stable until prog_ack is sampled high; prog_data SHALL be latched in that cycle; prog_req low in all other states.
REQ-024 Minimum latency SHALL be 4 cycles per instruction (prog_ack in first FETCH cycle); each wait cycle adds one.
REQ-025 op_code, source*_choice and imm SHALL be registered in DECODE and held stable through WB.
REQ-026 LD (0x1F): source1_choice = src field; NOT/STN/ST (0x06, 0x1E, 0x1D): source1_choice = 2; two-operand ops 0x00-0x11: source1_choice = 2, source2_choice = src field.
REQ-027 WB: ops 0x00-0x11, 0x1F SHALL load acc from alu_out; ST, STN, S (0x1B), R (0x1C) SHALL pulse mem_we and leave acc unchanged.
REQ-028 ADD (0x07) SHALL update carry from alu_c_out; SUB (0x08) SHALL update borrow from alu_b_out; all other ops SHALL leave both flags unchanged.
REQ-029 DIV/MOD (0x0A/0x0B) with zero operand (imm=0 when src=3) SHALL pulse err in WB and suppress the acc write.
REQ-030 Opcodes 0x12-0x1A, 0x20-0xFE (except per REQ-037) SHALL be illegal: err pulse in DECODE, no writes, PC+1, back to FETCH.
REQ-031 PC SHALL increment by 1 in WB and wrap from 2^PC_WIDTH-1 to 0.
REQ-032 0xFF SHALL enter HALT in DECODE; HALT SHALL exit only via rst; run is ignored.
REQ-033 run falling mid-instruction SHALL complete the instruction, then enter IDLE.

Reset
REQ-034 rst SHALL force IDLE, PC=0, acc=0, carry=0, borrow=0, and all outputs to 0 on the next edge, including mid-fetch (prog_req drops) and in HALT.
REQ-035 After rst release, the first fetch SHALL be at address 0.

Configuration
REQ-036 Macro IL_JUMP_EN SHALL compile in jump support; without it, 0x20/0x21 are illegal per REQ-030.
REQ-037 With IL_JUMP_EN: JMP (0x20) sets PC=imm[PC_WIDTH-1:0]; JMPC (0x21) does so only if acc[0]=1, else PC+1; neither writes acc, flags or memory.

Structure
REQ-038 Shared package il_pkg SHALL hold opcode constants, source-select encodings and the FSM state typedef.
REQ-039 Combinational sub-module il_decode SHALL map opcode to source selects, write class and legality.

Verification
REQ-040 LD imm 0x05, ADD imm 0x03 -> acc=0x08, carry=0, PC=2.
REQ-041 acc=0xFF, ADD imm 0x01 -> acc=0x00, carry=1; following ADD imm 0x00 -> acc=0x01.
REQ-042 prog_ack delayed 3 cycles -> prog_req/prog_addr stable for 3 cycles, instruction takes 7 cycles.
REQ-043 Opcode 0x15 at PC=0xFF -> err pulse, acc unchanged, PC wraps to 0x00.
REQ-044 rst asserted in FETCH with prog_req high -> next cycle IDLE, prog_req=0, PC=0; 0xFF -> halted=1 until rst.
